// File: rtl/mm_sequencer.sv
// Sequences a matrix-multiply sweep: fetches one A word per step and streams its s vector.
// Latency: A word presented MEM_LAT+1 cycles after FETCH_A entry; s beats follow as the prefetch FIFO fills.
// Backpressure: A and s streams hold until ready; s prefetch stalls when FIFO plus in-flight reads reach SFIFO.
//
// Ports:
//   clk_in, rst_in            clock and asynchronous active-low reset
//   start / busy / done       sweep control and status (done is a one-cycle pulse)
//   a_rd_en/a_addr/a_rd_data  A memory read port (fixed MEM_LAT read latency)
//   s_rd_en/s_addr/s_rd_data  s memory read port (fixed MEM_LAT read latency)
//   A_valid/pk_A/A_idx/A_ready  A word stream to the multiplier, h_out is the current row tag
//   s_valid/sk_s/s_idx/s_ready  s value stream to the multiplier
//   B_valid/B_ready/beat_count  multiplier output beat monitor
module mm_sequencer #(
  parameter int ROWS    = 28,
  parameter int A_COUNT = 4,
  parameter int S_COUNT = 783,
  parameter int MEM_LAT = 2,
  parameter int SFIFO   = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        a_rd_en,
  output logic [9:0]  a_addr,
  input  logic [35:0] a_rd_data,
  output logic        s_rd_en,
  output logic [9:0]  s_addr,
  input  logic [1:0]  s_rd_data,
  output logic        A_valid,
  output logic [35:0] pk_A,
  output logic [9:0]  A_idx,
  input  logic        A_ready,
  output logic        s_valid,
  output logic [1:0]  sk_s,
  output logic [9:0]  s_idx,
  input  logic        s_ready,
  output logic [9:0]  h_out,
  input  logic        B_valid,
  input  logic        B_ready,
  output logic [19:0] beat_count
);

  localparam logic [9:0]  A_LAST     = 10'(A_COUNT - 1);
  localparam logic [9:0]  ROW_LAST   = 10'(ROWS - 1);
  localparam logic [9:0]  S_LAST     = 10'(S_COUNT - 1);
  localparam logic [9:0]  A_CNT      = 10'(A_COUNT);
  localparam logic [19:0] BEAT_TOTAL = 20'(ROWS * A_COUNT * S_COUNT);
  localparam logic [19:0] BEAT_MAX   = '1;
  localparam int          PW         = (SFIFO > 1) ? $clog2(SFIFO) : 1;
  localparam int          CW         = $clog2(SFIFO + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(SFIFO - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH_A, PRESENT_A, STREAM_S, ADVANCE, DRAIN, FINISH
  } state_t;

  state_t         state_q, state_d;
  logic           busy_q, busy_d;
  logic [9:0]     row_q, row_d;
  logic [9:0]     a_q, a_d;
  logic [19:0]    beat_q, beat_d;
  logic           a_issued_q, a_issued_d;
  logic [35:0]    pk_a_q, pk_a_d;
  logic [MEM_LAT-1:0] a_vld_pipe_q, a_vld_pipe_d;

  // s prefetch: read index, active flag and a latency-matched pipe of in-flight indices
  logic [9:0]     s_rd_idx_q, s_rd_idx_d;
  logic           s_pref_q, s_pref_d;
  logic [MEM_LAT-1:0] s_vld_pipe_q, s_vld_pipe_d;
  logic [9:0]     s_idx_pipe_q [MEM_LAT];
  logic [9:0]     s_idx_pipe_d [MEM_LAT];

  // s FIFO
  logic [1:0]     fifo_dat_q [SFIFO];
  logic [9:0]     fifo_idx_q [SFIFO];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  fifo_cnt_q, fifo_cnt_d;
  logic           fifo_push, fifo_pop;

  logic [7:0]     in_flight;
  logic           pref_restart;

  assign busy       = busy_q;
  assign a_addr     = row_q * A_CNT + a_q;
  assign s_addr     = s_rd_idx_q;
  assign pk_A       = pk_a_q;
  assign A_idx      = a_q;
  assign h_out      = row_q;
  assign sk_s       = fifo_dat_q[rd_ptr_q];
  assign s_idx      = fifo_idx_q[rd_ptr_q];
  assign beat_count = beat_q;

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    row_d        = row_q;
    a_d          = a_q;
    beat_d       = beat_q;
    a_issued_d   = a_issued_q;
    pk_a_d       = pk_a_q;
    s_rd_idx_d   = s_rd_idx_q;
    s_pref_d     = s_pref_q;
    a_vld_pipe_d = '0;
    s_vld_pipe_d = '0;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_cnt_d   = fifo_cnt_q;
    a_rd_en      = 1'b0;
    A_valid      = 1'b0;
    s_valid      = 1'b0;
    done         = 1'b0;
    pref_restart = 1'b0;

    // Occupancy counts the head being popped this cycle, so the bound is conservative
    // and the FIFO can never overflow.
    in_flight = '0;
    for (int i = 0; i < MEM_LAT; i++) begin
      in_flight = in_flight + 8'(s_vld_pipe_q[i]);
    end
    s_rd_en = s_pref_q && ((8'(fifo_cnt_q) + in_flight) < 8'(SFIFO));

    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d       = 1'b1;
          row_d        = '0;
          a_d          = '0;
          beat_d       = '0;
          pref_restart = 1'b1;
          state_d      = FETCH_A;
        end
      end
      FETCH_A: begin
        a_rd_en = !a_issued_q;
        if (!a_issued_q) a_issued_d = 1'b1;
        if (a_vld_pipe_q[MEM_LAT-1]) begin
          pk_a_d     = a_rd_data;
          a_issued_d = 1'b0;
          state_d    = PRESENT_A;
        end
      end
      PRESENT_A: begin
        A_valid = 1'b1;
        if (A_ready) state_d = STREAM_S;
      end
      STREAM_S: begin
        s_valid = (fifo_cnt_q != '0);
        if (s_valid && s_ready && (s_idx == S_LAST)) state_d = ADVANCE;
      end
      ADVANCE: begin
        if (a_q == A_LAST) begin
          a_d   = '0;
          row_d = row_q + 10'd1;
        end else begin
          a_d = a_q + 10'd1;
        end
        if ((a_q == A_LAST) && (row_q == ROW_LAST)) begin
          state_d = DRAIN;
        end else begin
          pref_restart = 1'b1;
          state_d      = FETCH_A;
        end
      end
      // Extra beats beyond the expected total still release the drain.
      DRAIN: begin
        if (beat_q >= BEAT_TOTAL) state_d = FINISH;
      end
      FINISH: begin
        done    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (busy_q && B_valid && B_ready && (beat_q != BEAT_MAX)) beat_d = beat_q + 20'd1;

    // Each A word restarts the s sweep at index 0; the previous sweep is fully
    // consumed by then, so a restart never collides with an active prefetch.
    if (pref_restart) begin
      s_pref_d   = 1'b1;
      s_rd_idx_d = '0;
    end else if (s_rd_en) begin
      if (s_rd_idx_q == S_LAST) s_pref_d = 1'b0;
      else                      s_rd_idx_d = s_rd_idx_q + 10'd1;
    end

    a_vld_pipe_d[0]   = a_rd_en;
    s_vld_pipe_d[0]   = s_rd_en;
    s_idx_pipe_d[0]   = s_rd_idx_q;
    for (int i = 1; i < MEM_LAT; i++) begin
      a_vld_pipe_d[i] = a_vld_pipe_q[i-1];
      s_vld_pipe_d[i] = s_vld_pipe_q[i-1];
      s_idx_pipe_d[i] = s_idx_pipe_q[i-1];
    end

    fifo_push = s_vld_pipe_q[MEM_LAT-1];
    fifo_pop  = s_valid && s_ready;
    if (fifo_push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
    if (fifo_pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
    case ({fifo_push, fifo_pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      row_q        <= '0;
      a_q          <= '0;
      beat_q       <= '0;
      a_issued_q   <= 1'b0;
      pk_a_q       <= '0;
      a_vld_pipe_q <= '0;
      s_rd_idx_q   <= '0;
      s_pref_q     <= 1'b0;
      s_vld_pipe_q <= '0;
      for (int i = 0; i < MEM_LAT; i++) s_idx_pipe_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      row_q        <= row_d;
      a_q          <= a_d;
      beat_q       <= beat_d;
      a_issued_q   <= a_issued_d;
      pk_a_q       <= pk_a_d;
      a_vld_pipe_q <= a_vld_pipe_d;
      s_rd_idx_q   <= s_rd_idx_d;
      s_pref_q     <= s_pref_d;
      s_vld_pipe_q <= s_vld_pipe_d;
      for (int i = 0; i < MEM_LAT; i++) s_idx_pipe_q[i] <= s_idx_pipe_d[i];
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
    end
  end

  // FIFO storage needs no reset: contents are only observed while the count is non-zero.
  always_ff @(posedge clk_in) begin
    if (fifo_push) begin
      fifo_dat_q[wr_ptr_q] <= s_rd_data;
      fifo_idx_q[wr_ptr_q] <= s_idx_pipe_q[MEM_LAT-1];
    end
  end

endmodule

// File: tb/tb_mm_sequencer.sv
module tb_mm_sequencer;

  localparam int ROWS    = 2;
  localparam int A_COUNT = 3;
  localparam int S_COUNT = 10;
  localparam int MEM_LAT = 2;
  localparam int SFIFO   = 4;
  localparam int TOTAL   = ROWS * A_COUNT * S_COUNT;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        start;
  logic        busy, done;
  logic        a_rd_en;
  logic [9:0]  a_addr;
  logic [35:0] a_rd_data;
  logic        s_rd_en;
  logic [9:0]  s_addr;
  logic [1:0]  s_rd_data;
  logic        A_valid;
  logic [35:0] pk_A;
  logic [9:0]  A_idx;
  logic        A_ready;
  logic        s_valid;
  logic [1:0]  sk_s;
  logic [9:0]  s_idx;
  logic        s_ready;
  logic [9:0]  h_out;
  logic        B_valid, B_ready;
  logic [19:0] beat_count;

  always #5 clk_in = ~clk_in;

  mm_sequencer #(
    .ROWS(ROWS), .A_COUNT(A_COUNT), .S_COUNT(S_COUNT), .MEM_LAT(MEM_LAT), .SFIFO(SFIFO)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start(start), .busy(busy), .done(done),
    .a_rd_en(a_rd_en), .a_addr(a_addr), .a_rd_data(a_rd_data),
    .s_rd_en(s_rd_en), .s_addr(s_addr), .s_rd_data(s_rd_data),
    .A_valid(A_valid), .pk_A(pk_A), .A_idx(A_idx), .A_ready(A_ready),
    .s_valid(s_valid), .sk_s(sk_s), .s_idx(s_idx), .s_ready(s_ready),
    .h_out(h_out), .B_valid(B_valid), .B_ready(B_ready), .beat_count(beat_count)
  );

  function automatic logic [35:0] a_word(input logic [9:0] addr);
    return {16'hA5C3, addr, addr ^ 10'h2B7};
  endfunction

  function automatic logic [1:0] s_val(input logic [9:0] addr);
    return addr[1:0] ^ addr[3:2] ^ {addr[4], addr[5]};
  endfunction

  // Memories with a two-cycle read latency; off-cycle data is deliberately wrong.
  logic [35:0] a_p0, a_p1;
  logic [1:0]  s_p0, s_p1;
  always @(posedge clk_in) begin
    a_p0 <= a_rd_en ? a_word(a_addr) : 36'h0DEAD0BAD;
    a_p1 <= a_p0;
    s_p0 <= s_rd_en ? s_val(s_addr) : ~s_val(s_addr);
    s_p1 <= s_p0;
  end
  assign a_rd_data = a_p1;
  assign s_rd_data = s_p1;

  typedef struct packed { logic [35:0] pk; logic [9:0] idx; logic [9:0] h; } a_exp_t;
  typedef struct packed { logic [1:0] dat; logic [9:0] idx; } s_exp_t;
  a_exp_t exp_a[$];
  s_exp_t exp_s[$];

  int total = 0;
  int bad = 0;
  int done_cnt, outstanding, s_xfers, a_rd_cnt, b_force_left;
  logic [9:0] exp_aaddr, exp_saddr;
  bit rand_ready, b_echo_en, start_on_done;
  bit prev_a_stall, prev_s_stall;
  logic [35:0] prev_pk;
  logic [9:0]  prev_aidx, prev_h, prev_sidx;
  logic [1:0]  prev_sk;

  task automatic push_expected();
    a_exp_t ea;
    s_exp_t es;
    for (int r = 0; r < ROWS; r++) begin
      for (int a = 0; a < A_COUNT; a++) begin
        ea.pk  = a_word(10'(r * A_COUNT + a));
        ea.idx = 10'(a);
        ea.h   = 10'(r);
        exp_a.push_back(ea);
        for (int s = 0; s < S_COUNT; s++) begin
          es.dat = s_val(10'(s));
          es.idx = 10'(s);
          exp_s.push_back(es);
        end
      end
    end
  endtask

  task automatic flush_model();
    exp_a.delete();
    exp_s.delete();
    outstanding  = 0;
    prev_a_stall = 0;
    prev_s_stall = 0;
    B_valid      = 1'b0;
    b_force_left = 0;
  endtask

  // One clock: sample everything at the falling edge, score transfers, then drive inputs.
  task automatic clock_cycle();
    a_exp_t ea;
    s_exp_t es;
    bit s_xfer;
    bit poke;
    @(negedge clk_in);
    poke = 0;
    if (done === 1'b1) begin
      done_cnt++;
      if (start_on_done) begin
        start = 1'b1;
        poke  = 1;
      end
    end
    if (prev_a_stall) begin
      total++;
      if (A_valid !== 1'b1 || pk_A !== prev_pk || A_idx !== prev_aidx || h_out !== prev_h) begin
        bad++;
        $display("FAIL a_hold: got v=%b pk=%h idx=%0d h=%0d, want v=1 pk=%h idx=%0d h=%0d",
                 A_valid, pk_A, A_idx, h_out, prev_pk, prev_aidx, prev_h);
      end
    end
    if (prev_s_stall) begin
      total++;
      if (s_valid !== 1'b1 || sk_s !== prev_sk || s_idx !== prev_sidx) begin
        bad++;
        $display("FAIL s_hold: got v=%b sk=%0d idx=%0d, want v=1 sk=%0d idx=%0d",
                 s_valid, sk_s, s_idx, prev_sk, prev_sidx);
      end
    end
    if (busy !== 1'b1 || done === 1'b1) begin
      total++;
      if (A_valid !== 1'b0 || s_valid !== 1'b0) begin
        bad++;
        $display("FAIL idle_valid: got A_valid=%b s_valid=%b, want 0 0", A_valid, s_valid);
      end
    end
    if (a_rd_en === 1'b1) begin
      total++;
      a_rd_cnt++;
      if (a_addr !== exp_aaddr) begin
        bad++;
        $display("FAIL a_addr: got %0d, want %0d", a_addr, exp_aaddr);
      end
      exp_aaddr = exp_aaddr + 10'd1;
    end
    if (s_rd_en === 1'b1) begin
      total++;
      if (s_addr !== exp_saddr) begin
        bad++;
        $display("FAIL s_addr: got %0d, want %0d", s_addr, exp_saddr);
      end
      exp_saddr = (exp_saddr == 10'(S_COUNT - 1)) ? 10'd0 : exp_saddr + 10'd1;
      outstanding++;
      total++;
      if (outstanding > SFIFO) begin
        bad++;
        $display("FAIL s_occupancy: got %0d outstanding, want <= %0d", outstanding, SFIFO);
      end
    end
    if (A_valid === 1'b1 && A_ready === 1'b1) begin
      total++;
      if (exp_a.size() == 0) begin
        bad++;
        $display("FAIL a_extra: got idx=%0d h=%0d, want no transfer", A_idx, h_out);
      end else begin
        ea = exp_a.pop_front();
        if (pk_A !== ea.pk || A_idx !== ea.idx || h_out !== ea.h) begin
          bad++;
          $display("FAIL a_xfer: got pk=%h idx=%0d h=%0d, want pk=%h idx=%0d h=%0d",
                   pk_A, A_idx, h_out, ea.pk, ea.idx, ea.h);
        end
      end
    end
    s_xfer = (s_valid === 1'b1 && s_ready === 1'b1);
    if (s_xfer) begin
      total++;
      s_xfers++;
      outstanding--;
      if (exp_s.size() == 0) begin
        bad++;
        $display("FAIL s_extra: got idx=%0d, want no transfer", s_idx);
      end else begin
        es = exp_s.pop_front();
        if (sk_s !== es.dat || s_idx !== es.idx) begin
          bad++;
          $display("FAIL s_xfer: got sk=%0d idx=%0d, want sk=%0d idx=%0d", sk_s, s_idx, es.dat, es.idx);
        end
      end
    end
    prev_a_stall = (A_valid === 1'b1 && A_ready !== 1'b1);
    prev_pk = pk_A; prev_aidx = A_idx; prev_h = h_out;
    prev_s_stall = (s_valid === 1'b1 && s_ready !== 1'b1);
    prev_sk = sk_s; prev_sidx = s_idx;
    @(posedge clk_in);
    #1;
    if (poke) start = 1'b0;
    B_valid = (b_force_left > 0) || (b_echo_en && s_xfer);
    if (b_force_left > 0) b_force_left--;
    if (rand_ready) begin
      A_ready = 1'($urandom_range(0, 1));
      s_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic start_sweep(input string tag);
    done_cnt  = 0;
    s_xfers   = 0;
    exp_aaddr = '0;
    exp_saddr = '0;
    push_expected();
    start = 1'b1;
    clock_cycle();
    start = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL %s_start: got busy=%b, want 1", tag, busy);
    end
  endtask

  task automatic wait_sweep_end(input int max_cycles, input string tag);
    int n = 0;
    while (done_cnt == 0 && n < max_cycles) begin
      clock_cycle();
      n++;
    end
    total++;
    if (done_cnt != 1) begin
      bad++;
      $display("FAIL %s_done: got %0d done pulses after %0d cycles, want 1", tag, done_cnt, n);
    end
    clock_cycle();
    total++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_after: got done_cnt=%0d busy=%b, want 1 0", tag, done_cnt, busy);
    end
    total++;
    if (beat_count !== 20'(TOTAL)) begin
      bad++;
      $display("FAIL %s_beats: got %0d, want %0d", tag, beat_count, TOTAL);
    end
    total++;
    if (exp_a.size() != 0 || exp_s.size() != 0) begin
      bad++;
      $display("FAIL %s_left: got %0d A and %0d s untransferred, want 0 0", tag, exp_a.size(), exp_s.size());
    end
  endtask

  task automatic wait_s_xfers(input int target, input string tag);
    int n = 0;
    while (s_xfers < target && n < 1000) begin
      clock_cycle();
      n++;
    end
    total++;
    if (s_xfers < target) begin
      bad++;
      $display("FAIL %s_timeout: got %0d s transfers, want %0d", tag, s_xfers, target);
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    for (int i = 0; i < 3; i++) clock_cycle();
    total++;
    if ({busy, done, a_rd_en, s_rd_en, A_valid, s_valid} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got busy/done/a_rd/s_rd/Av/sv=%b, want 000000",
               {busy, done, a_rd_en, s_rd_en, A_valid, s_valid});
    end
    total++;
    if (beat_count !== 20'd0) begin
      bad++;
      $display("FAIL reset_beats: got %0d, want 0", beat_count);
    end
    rst_in = 1'b1;
    start_sweep("reset_first_edge");
    wait_sweep_end(2000, "basic");
  endtask

  task automatic test_s_backpressure();
    start_sweep("bp");
    wait_s_xfers(15, "bp");
    s_ready = 1'b0;
    for (int i = 0; i < 10; i++) clock_cycle();
    total++;
    if (s_valid !== 1'b1) begin
      bad++;
      $display("FAIL bp_stalled_valid: got s_valid=%b, want 1", s_valid);
    end
    s_ready = 1'b1;
    wait_sweep_end(2000, "bp");
  endtask

  task automatic test_start_ignored();
    logic [19:0] b0;
    int rd0;
    start_sweep("ign");
    wait_s_xfers(8, "ign");
    b0 = beat_count;
    start = 1'b1;
    clock_cycle();
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || beat_count < b0 || b0 == 20'd0) begin
      bad++;
      $display("FAIL ign_busy_start: got busy=%b beats=%0d (before %0d), want busy=1 beats kept", busy, beat_count, b0);
    end
    start_on_done = 1;
    wait_sweep_end(2000, "ign");
    start_on_done = 0;
    rd0 = a_rd_cnt;
    b_force_left = 3;
    for (int i = 0; i < 6; i++) clock_cycle();
    total++;
    if (busy !== 1'b0 || a_rd_cnt != rd0 || beat_count !== 20'(TOTAL)) begin
      bad++;
      $display("FAIL ign_finish_start: got busy=%b a_reads=%0d beats=%0d, want 0 %0d %0d",
               busy, a_rd_cnt - rd0, beat_count, 0, TOTAL);
    end
    start_sweep("ign_next");
    wait_sweep_end(2000, "ign_next");
  endtask

  task automatic test_reset_mid_stream();
    int n = 0;
    start_sweep("rst");
    while (!(s_xfers >= 5 && s_valid === 1'b1 && s_rd_en === 1'b1) && n < 1000) begin
      clock_cycle();
      n++;
    end
    total++;
    if (s_xfers < 5) begin
      bad++;
      $display("FAIL rst_reach_stream: got %0d s transfers, want >= 5", s_xfers);
    end
    rst_in = 1'b0;
    #1;
    total++;
    if ({busy, done, a_rd_en, s_rd_en, A_valid, s_valid} !== 6'b0 || beat_count !== 20'd0) begin
      bad++;
      $display("FAIL rst_async: got ctrl=%b beats=%0d, want 000000 0",
               {busy, done, a_rd_en, s_rd_en, A_valid, s_valid}, beat_count);
    end
    flush_model();
    done_cnt = 0;
    clock_cycle();
    rst_in = 1'b1;
    total++;
    if (done_cnt != 0) begin
      bad++;
      $display("FAIL rst_no_done: got %0d done pulses, want 0", done_cnt);
    end
    start_sweep("rst_fresh");
    wait_sweep_end(2000, "rst_fresh");
  endtask

  task automatic test_random_ready();
    rand_ready = 1;
    start_sweep("rand");
    wait_sweep_end(4000, "rand");
    rand_ready = 0;
    A_ready = 1'b1;
    s_ready = 1'b1;
  endtask

  task automatic test_drain_stall();
    int n = 0;
    b_echo_en = 0;
    start_sweep("drain");
    while (exp_s.size() != 0 && n < 2000) begin
      clock_cycle();
      n++;
    end
    for (int i = 0; i < 30; i++) clock_cycle();
    total++;
    if (busy !== 1'b1 || done_cnt != 0 || beat_count !== 20'd0 || A_valid !== 1'b0 || s_valid !== 1'b0) begin
      bad++;
      $display("FAIL drain_hold: got busy=%b dones=%0d beats=%0d Av=%b sv=%b, want 1 0 0 0 0",
               busy, done_cnt, beat_count, A_valid, s_valid);
    end
    b_force_left = TOTAL;
    wait_sweep_end(500, "drain");
    b_echo_en = 1;
  endtask

  initial begin
    rst_in        = 1'b0;
    start         = 1'b0;
    A_ready       = 1'b1;
    s_ready       = 1'b1;
    B_valid       = 1'b0;
    B_ready       = 1'b1;
    rand_ready    = 0;
    b_echo_en     = 1;
    start_on_done = 0;
    done_cnt      = 0;
    s_xfers       = 0;
    a_rd_cnt      = 0;
    exp_aaddr     = '0;
    exp_saddr     = '0;
    flush_model();
    test_reset();
    test_s_backpressure();
    test_start_ignored();
    test_reset_mid_stream();
    test_random_ready();
    test_drain_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
